// File: rtl/refresh_countdown_timer.sv
// Periodic tREFI down-counter with refresh credit accounting.
// Expiries accumulate as credits that are retired by refresh_ack.
module refresh_countdown_timer #(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               clear,
    input  logic                               enable,
    input  logic [SIZE-1:0]                    interval_val,
    input  logic                               refresh_ack,
    output logic [SIZE-1:0]                    count_out,
    output logic                               expire_pulse,
    output logic                               refresh_req,
    output logic                               refresh_urgent,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
    output logic                               overflow_err
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    logic   expiry;

    // Expiry edge: the enabled RUN cycle on which the countdown reaches 1
    always_comb begin
        expiry = 1'b0;
        if ((state == RUN) && enable && (count_out <= SIZE'(1))) begin
            expiry = 1'b1;
        end
    end

    assign refresh_req    = (pending_cnt != '0);
    assign refresh_urgent = (pending_cnt == PEND_MAX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            count_out    <= '0;
            expire_pulse <= 1'b0;
            pending_cnt  <= '0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            count_out    <= '0;
            expire_pulse <= 1'b0;
            pending_cnt  <= '0;
            overflow_err <= 1'b0;
        end else begin
            expire_pulse <= expiry;

            case (state)
                IDLE: begin
                    if (enable && (interval_val != '0)) begin
                        count_out <= interval_val;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (expiry) begin
                        // Reload samples the interval; zero parks the timer
                        count_out <= interval_val;
                        if (interval_val == '0) begin
                            state <= IDLE;
                        end
                    end else if (enable) begin
                        count_out <= count_out - SIZE'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    count_out <= '0;
                end
            endcase

            // Credit counter: simultaneous expiry and ack cancel out
            if (expiry && !refresh_ack) begin
                if (pending_cnt == PEND_MAX) begin
                    overflow_err <= 1'b1;
                end else begin
                    pending_cnt <= pending_cnt + PEND_W'(1);
                end
            end else if (refresh_ack && !expiry && (pending_cnt != '0)) begin
                pending_cnt <= pending_cnt - PEND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_refresh_countdown_timer.sv
// Scoreboard bench for refresh_countdown_timer: driver pushes model predictions,
// monitor pops and compares one entry per clock after each rising edge.
module tb_refresh_countdown_timer;

    localparam int unsigned SIZE        = 16;
    localparam int unsigned MAX_PENDING = 8;
    localparam int unsigned PEND_W      = $clog2(MAX_PENDING + 1);

    logic              clk;
    logic              n_rst;
    logic              clear;
    logic              enable;
    logic [SIZE-1:0]   interval_val;
    logic              refresh_ack;
    logic [SIZE-1:0]   count_out;
    logic              expire_pulse;
    logic              refresh_req;
    logic              refresh_urgent;
    logic [PEND_W-1:0] pending_cnt;
    logic              overflow_err;

    refresh_countdown_timer #(
        .SIZE        (SIZE),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .enable         (enable),
        .interval_val   (interval_val),
        .refresh_ack    (refresh_ack),
        .count_out      (count_out),
        .expire_pulse   (expire_pulse),
        .refresh_req    (refresh_req),
        .refresh_urgent (refresh_urgent),
        .pending_cnt    (pending_cnt),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit pulse;
        bit req;
        bit urgent;
        int pend;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: timer described as "cycles remaining in the period"
    bit m_running = 0;
    int m_left    = 0;
    int m_pend    = 0;
    bit m_ovf     = 0;
    bit m_pulse   = 0;
    bit prev_rst  = 0;
    int cur_iv    = 4;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit clr, input bit en,
                                       input bit ack, input int iv);
        bit fire;
        if (!rst || clr) begin
            m_running = 0; m_left = 0; m_pend = 0; m_ovf = 0; m_pulse = 0;
            return;
        end
        fire    = m_running && en && (m_left == 1);
        m_pulse = fire;
        if (!m_running) begin
            if (en && iv != 0) begin
                m_running = 1;
                m_left    = iv;
            end
        end else if (fire) begin
            m_left = iv;
            if (iv == 0) m_running = 0;
        end else if (en) begin
            m_left = m_left - 1;
        end
        if (fire && !ack) begin
            if (m_pend == MAX_PENDING) m_ovf = 1;
            else m_pend = m_pend + 1;
        end else if (ack && !fire) begin
            m_pend = (m_pend > 0) ? m_pend - 1 : 0;
        end
    endfunction

    task automatic step(input bit rst, input bit clr, input bit en, input bit ack, input int iv);
        exp_t e;
        @(negedge clk);
        n_rst        = rst;
        clear        = clr;
        enable       = en;
        refresh_ack  = ack;
        interval_val = SIZE'(iv);
        cur_iv       = iv;
        model_step(rst, clr, en, ack, iv);
        e.count  = m_left;
        e.pulse  = m_pulse;
        e.req    = (m_pend != 0);
        e.urgent = (m_pend == MAX_PENDING);
        e.pend   = m_pend;
        e.ovf    = m_ovf;
        exp_q.push_back(e);
        // Asynchronous reset must zero the outputs without waiting for a clock
        if (!rst && prev_rst) begin
            #1;
            chk("async_rst_count", int'(count_out), 0);
            chk("async_rst_pend", int'(pending_cnt), 0);
            chk("async_rst_ovf", int'(overflow_err), 0);
            chk("async_rst_req", int'(refresh_req), 0);
        end
        prev_rst = rst;
    endtask

    // Monitor: the DUT presents a new output set after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count_out", int'(count_out), e.count);
                chk("expire_pulse", int'(expire_pulse), int'(e.pulse));
                chk("refresh_req", int'(refresh_req), int'(e.req));
                chk("refresh_urgent", int'(refresh_urgent), int'(e.urgent));
                chk("pending_cnt", int'(pending_cnt), e.pend);
                chk("overflow_err", int'(overflow_err), int'(e.ovf));
            end
        end
    end

    initial begin
        int iv;
        bit ack;
        n_rst = 1'b0; clear = 1'b0; enable = 1'b0; refresh_ack = 1'b0;
        interval_val = '0;

        repeat (3) step(0, 0, 1, 0, 4);

        // Free-running period of 4
        repeat (12) step(1, 0, 1, 0, 4);

        // Ack landing on an expiry edge leaves the credit count unchanged
        for (int i = 0; i < 20 && !(m_running && m_left == 1); i++) step(1, 0, 1, 0, 4);
        step(1, 0, 1, 1, 4);
        repeat (2) step(1, 0, 1, 0, 4);

        // Saturation and sticky overflow with no acks
        step(1, 1, 0, 0, 4);
        repeat (44) step(1, 0, 1, 0, 4);
        repeat (3) step(1, 0, 0, 0, 4);

        // Pause at count 2 while an ack still retires a credit
        step(1, 1, 0, 0, 4);
        for (int i = 0; i < 40 && !(m_pend == 2 && m_left == 2); i++) step(1, 0, 1, 0, 4);
        step(1, 0, 0, 0, 4);
        step(1, 0, 0, 1, 4);
        repeat (3) step(1, 0, 0, 0, 4);
        repeat (4) step(1, 0, 1, 0, 4);

        // Clear mid-run, then asynchronous reset mid-run
        for (int i = 0; i < 40 && m_pend < 3; i++) step(1, 0, 1, 0, 4);
        step(1, 0, 1, 0, 4);
        step(1, 1, 1, 1, 4);
        repeat (6) step(1, 0, 1, 0, 4);
        step(0, 0, 1, 0, 4);
        step(0, 0, 1, 0, 4);
        repeat (3) step(1, 0, 1, 0, 4);

        // Interval change mid-count, then interval 0 on an expiry edge
        step(1, 1, 0, 0, 4);
        for (int i = 0; i < 10 && !(m_running && m_left == 3); i++) step(1, 0, 1, 0, 4);
        repeat (14) step(1, 0, 1, 0, 6);
        for (int i = 0; i < 10 && !(m_running && m_left == 1); i++) step(1, 0, 1, 0, 6);
        step(1, 0, 1, 0, 0);
        repeat (3) step(1, 0, 1, 0, 0);

        // Randomized traffic, small intervals so expiries and saturation are common
        iv = 3;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) iv = int'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) iv = int'($urandom_range(7, 20));
            ack = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) != 0), ack, iv);
        end

        @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
